fetch_ctrl: RTL and testbench



---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_ctrl.sv | 101 ++++++++++
 tb/tb_fetch_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: data width, reset vector default, PC step and alignment mask.
package riscv_pkg;

  localparam int          XLEN          = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INCR       = 32'd4;
  localparam logic [1:0]  ALIGN_MASK    = 2'b11;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_KILL  = 3'd4,
    ST_FAULT = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch sequencer with redirect/flush and misaligned-target fault.
// Handshake to if_valid takes at least 2 cycles; decode stalls hold the word and suppress new requests.
module fetch_ctrl #(
  parameter int          XLEN      = riscv_pkg::XLEN,
  parameter logic [31:0] RESET_VEC = riscv_pkg::RESET_VEC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);
  import riscv_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc, pc_d;
  logic            req_hs;
  logic            redir_mis;
  logic            latch_rsp;

  assign req_hs    = (state_q == ST_REQ) && imem_req_ready;
  assign redir_mis = |(redirect_pc[1:0] & ALIGN_MASK);

  always_comb begin
    state_d   = state_q;
    pc_d      = fetch_pc;
    latch_rsp = 1'b0;
    unique case (state_q)
      ST_RST: state_d = ST_REQ;
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = req_hs ? ST_KILL : (redir_mis ? ST_FAULT : ST_REQ);
        end else if (req_hs) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_rsp_valid ? (redir_mis ? ST_FAULT : ST_REQ) : ST_KILL;
        end else if (imem_rsp_valid) begin
          latch_rsp = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = redir_mis ? ST_FAULT : ST_REQ;
        end else if (if_ready) begin
          pc_d    = fetch_pc + PC_INCR;
          state_d = ST_REQ;
        end
      end
      ST_KILL: begin
        if (redirect_valid) pc_d = redirect_pc;
        // The drained target decides whether fetch resumes or parks in FAULT.
        if (imem_rsp_valid) state_d = (|(pc_d[1:0] & ALIGN_MASK)) ? ST_FAULT : ST_REQ;
      end
      ST_FAULT: begin
        if (redirect_valid && !redir_mis) begin
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RST;
      fetch_pc <= RESET_VEC;
      if_pc    <= '0;
      if_instr <= '0;
    end else begin
      state_q  <= state_d;
      fetch_pc <= pc_d;
      if (latch_rsp) begin
        if_pc    <= fetch_pc;
        if_instr <= imem_rsp_data;
      end
    end
  end

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = fetch_pc;
  assign if_valid       = (state_q == ST_HOLD);
  assign fetch_fault    = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl: per-cycle stimulus/expectation table plus a PC wrap sequence.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.XLEN(32), .RESET_VEC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  // One row per clock: inputs held for the cycle, expectations on the state entering it.
  typedef struct {
    logic        rst, rdy, rsv;
    logic [31:0] rsd;
    logic        ifr, rdv;
    logic [31:0] rpc;
    logic        xrv;
    logic [31:0] xa;
    logic        xac, xifv, xchk;
    logic [31:0] xpc, xins;
    logic        xflt;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic void add(input logic rst, rdy, rsv, input logic [31:0] rsd,
                              input logic ifr, rdv, input logic [31:0] rpc,
                              input logic xrv, input logic [31:0] xa, input logic xac, xifv, xchk,
                              input logic [31:0] xpc, xins, input logic xflt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rsv = rsv; v.rsd = rsd; v.ifr = ifr; v.rdv = rdv; v.rpc = rpc;
    v.xrv = xrv; v.xa = xa; v.xac = xac; v.xifv = xifv; v.xchk = xchk;
    v.xpc = xpc; v.xins = xins; v.xflt = xflt;
    vt.push_back(v);
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    add(1,0,0,0,0,0,0,              0,0,1,0,1,0,0,0);
    add(0,1,0,0,0,0,0,              0,0,1,0,1,0,0,0);
    add(0,1,0,0,0,0,0,              1,0,1,0,0,0,0,0);
    add(0,0,1,ins(0),0,0,0,         0,0,1,0,0,0,0,0);
    add(0,0,0,0,1,0,0,              0,0,1,1,1,0,ins(0),0);
    for (int k = 0; k < 3; k++)
      add(0,0,0,0,0,0,0,            1,4,1,0,0,0,0,0);
    add(0,1,0,0,0,0,0,              1,4,1,0,0,0,0,0);
    add(0,0,1,ins(4),0,0,0,         0,4,1,0,0,0,0,0);
    add(0,0,0,0,1,0,0,              0,4,1,1,1,4,ins(4),0);
    add(0,1,0,0,0,0,0,              1,8,1,0,0,0,0,0);
    add(0,0,1,ins(8),0,0,0,         0,8,1,0,0,0,0,0);
    for (int k = 0; k < 5; k++)
      add(0,1,0,0,0,0,0,            0,8,1,1,1,8,ins(8),0);
    add(0,1,0,0,1,0,0,              0,8,1,1,1,8,ins(8),0);
    add(0,1,0,0,0,0,0,              1,32'hC,1,0,0,0,0,0);
    add(0,0,0,0,0,1,32'h100,        0,32'hC,1,0,0,0,0,0);
    add(0,0,0,0,0,0,0,              0,32'h100,1,0,0,0,0,0);
    add(0,0,1,ins(32'hC),0,0,0,     0,32'h100,1,0,0,0,0,0);
    add(0,1,0,0,0,0,0,              1,32'h100,1,0,0,0,0,0);
    add(0,0,1,ins(32'h100),0,0,0,   0,32'h100,1,0,0,0,0,0);
    add(0,0,0,0,1,0,0,              0,32'h100,1,1,1,32'h100,ins(32'h100),0);
    add(0,0,0,0,0,1,32'h10,         1,32'h104,1,0,0,0,0,0);
    add(0,1,0,0,0,0,0,              1,32'h10,1,0,0,0,0,0);
    add(0,0,1,ins(32'h10),0,0,0,    0,32'h10,1,0,0,0,0,0);
    add(0,0,0,0,1,1,32'h200,        0,32'h10,1,1,1,32'h10,ins(32'h10),0);
    add(0,1,0,0,0,0,0,              1,32'h200,1,0,0,0,0,0);
    add(0,0,1,ins(32'h200),0,0,0,   0,32'h200,1,0,0,0,0,0);
    add(0,0,0,0,0,1,32'h102,        0,32'h200,1,1,1,32'h200,ins(32'h200),0);
    add(0,1,0,0,0,0,0,              0,32'h102,1,0,0,0,0,1);
    add(0,1,0,0,0,1,32'h306,        0,32'h102,1,0,0,0,0,1);
    add(0,1,0,0,0,1,32'h300,        0,0,0,0,0,0,0,1);
    add(0,1,0,0,0,0,0,              1,32'h300,1,0,0,0,0,0);
    add(0,0,0,0,0,1,32'h401,        0,32'h300,1,0,0,0,0,0);
    add(0,0,1,ins(32'h300),0,0,0,   0,32'h401,1,0,0,0,0,0);
    add(0,1,0,0,0,0,0,              0,32'h401,1,0,0,0,0,1);
    add(0,1,1,32'hDEAD,0,1,32'h500, 0,32'h401,1,0,0,0,0,1);
    add(0,1,0,0,0,0,0,              1,32'h500,1,0,0,0,0,0);
    add(0,0,1,ins(32'h500),0,1,32'h600, 0,32'h500,1,0,0,0,0,0);
    add(0,1,0,0,0,1,32'h700,        1,32'h600,1,0,0,0,0,0);
    add(0,0,1,ins(32'h600),0,1,32'h800, 0,32'h700,1,0,0,0,0,0);
    add(0,1,0,0,0,0,0,              1,32'h800,1,0,0,0,0,0);
    add(0,0,1,ins(32'h800),0,0,0,   0,32'h800,1,0,0,0,0,0);
    add(0,0,0,0,1,0,0,              0,32'h800,1,1,1,32'h800,ins(32'h800),0);
    add(0,0,1,32'hBAD,0,0,0,        1,32'h804,1,0,0,0,0,0);
    add(1,0,0,0,0,0,0,              1,32'h804,1,0,0,0,0,0);
    add(0,0,0,0,0,0,0,              0,0,1,0,1,0,0,0);
    add(0,0,0,0,0,0,0,              1,0,1,0,0,0,0,0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      reset = vt[i].rst; imem_req_ready = vt[i].rdy;
      imem_rsp_valid = vt[i].rsv; imem_rsp_data = vt[i].rsd;
      if_ready = vt[i].ifr; redirect_valid = vt[i].rdv; redirect_pc = vt[i].rpc;
      #1;
      chk("req_valid", i, {31'd0, imem_req_valid}, {31'd0, vt[i].xrv});
      if (vt[i].xac) chk("req_addr", i, imem_req_addr, vt[i].xa);
      chk("if_valid", i, {31'd0, if_valid}, {31'd0, vt[i].xifv});
      chk("fetch_fault", i, {31'd0, fetch_fault}, {31'd0, vt[i].xflt});
      if (vt[i].xchk) begin
        chk("if_pc", i, if_pc, vt[i].xpc);
        chk("if_instr", i, if_instr, vt[i].xins);
      end
    end

    // PC wrap: fetch at 0xFFFFFFFC, consume, next request must be 0x0.
    @(negedge clk);
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    chk("wrap_req_valid", 100, {31'd0, imem_req_valid}, 32'd1);
    chk("wrap_req_addr", 100, imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = ins(32'hFFFF_FFFC);
    #1;
    chk("wrap_wait_idle", 101, {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk);
    imem_rsp_valid = 1'b0; if_ready = 1'b1;
    #1;
    chk("wrap_if_valid", 102, {31'd0, if_valid}, 32'd1);
    chk("wrap_if_pc", 102, if_pc, 32'hFFFF_FFFC);
    chk("wrap_if_instr", 102, if_instr, ins(32'hFFFF_FFFC));
    @(negedge clk);
    if_ready = 1'b0;
    #1;
    chk("wrap_next_valid", 103, {31'd0, imem_req_valid}, 32'd1);
    chk("wrap_next_addr", 103, imem_req_addr, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
